load_store_unit: RTL and testbench

- Sits between the CPU MEM stage and the unified instruction/data memory's data port.
- The memory has a 1-cycle registered read and full-word writes only. This block adds byte/halfword loads with sign or zero extension, and byte/halfword stores via read-modify-write.
- It also detects misaligned and out-of-range accesses and stalls the pipeline while a multi-cycle access is in flight.

---
 rtl/load_store_unit_pkg.sv | 47 ++++
 rtl/load_store_unit_lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: word width, funct3 codes, FSM states.
// Latency: n/a (types, constants and one pure decode function).
// Backpressure: n/a.
package load_store_unit_pkg;

  localparam int WORD_LEN = 32;

  // RISC-V funct3 codes for the MEM-stage access
  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'd0,
    LSU_LOAD_DONE   = 2'd1,
    LSU_STORE_MERGE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Access width comes from funct3[1:0] only; every code that is not a
  // byte or halfword access (including the unused ones) is a full word.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    if (f3[1:0] == LSU_LB[1:0] || f3[1:0] == LSU_SB[1:0]) begin
      return SZ_BYTE;
    end else if (f3[1:0] == LSU_LH[1:0] || f3[1:0] == LSU_SH[1:0]) begin
      return SZ_HALF;
    end else begin
      return SZ_WORD;
    end
  endfunction

  // Zero extension applies only to LBU/LHU; all other loads sign-extend.
  function automatic logic lsu_is_unsigned(input logic [2:0] f3);
    return (f3 == LSU_LBU) || (f3 == LSU_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_lsu_align.sv
// Lane alignment: extracts and extends a load lane, merges store data into a word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [WORD_LEN-1:0] word,
  input  logic [1:0]          byte_off,
  input  logic [2:0]          funct3,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] load_val,
  output logic [WORD_LEN-1:0] store_word
);

  logic [4:0]          shamt;
  logic [WORD_LEN-1:0] shifted;
  logic [WORD_LEN-1:0] lane_mask;
  logic                uns;
  lsu_size_e           size;

  // Shift the addressed lane down for loads, build the lane mask for stores
  always_comb begin
    shamt      = {byte_off, 3'b000};
    shifted    = word >> shamt;
    size       = lsu_size(funct3);
    uns        = lsu_is_unsigned(funct3);
    load_val   = word;
    lane_mask  = '1;
    case (size)
      SZ_BYTE: begin
        load_val  = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        load_val  = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_val  = word;
        lane_mask = '1;
      end
    endcase
    store_word = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with extension, sub-word stores via read-modify-write.
// Latency: loads 2 cycles, SW 1 cycle, SB/SH 2 cycles, faults complete in the accept cycle.
// Backpressure: combinational stall held in the accept cycle of any 2-cycle access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_ren,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                stall,
  output logic [WORD_LEN-1:0] rdata,
  output logic                rdata_valid,
  output logic                fault,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  lsu_state_e          state_q, state_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;

  logic                accept;
  logic                misaligned;
  logic                out_of_range;
  lsu_size_e           req_size;
  logic [WORD_LEN-1:0] load_val;
  logic [WORD_LEN-1:0] store_word;

  // Lane logic always works on the latched request and the word from memory
  lsu_align u_align (
    .word       (mem_rdata),
    .byte_off   (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // Next-state, request latching and all outputs; idle values first
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    stall        = 1'b0;
    rdata        = '0;
    rdata_valid  = 1'b0;
    fault        = 1'b0;
    mem_wen      = 1'b0;
    mem_wdata    = '0;
    mem_addr     = {addr_q[31:2], 2'b00};

    accept       = req_wen | req_ren;
    req_size     = lsu_size(req_funct3);
    misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    out_of_range = req_addr[31:2] >= DEPTH_W;

    if (rst) begin
      state_d = LSU_IDLE;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          mem_addr = {req_addr[31:2], 2'b00};
          if (accept) begin
            addr_d   = req_addr;
            funct3_d = req_funct3;
            wdata_d  = req_wdata;
            if (misaligned || out_of_range) begin
              fault = 1'b1;
            end else if (req_wen) begin
              if (req_size == SZ_WORD) begin
                mem_wen   = 1'b1;
                mem_wdata = req_wdata;
              end else begin
                // Read the old word first; merge happens next cycle
                stall   = 1'b1;
                state_d = LSU_STORE_MERGE;
              end
            end else begin
              stall   = 1'b1;
              state_d = LSU_LOAD_DONE;
            end
          end
        end
        LSU_LOAD_DONE: begin
          rdata       = load_val;
          rdata_valid = 1'b1;
          state_d     = LSU_IDLE;
        end
        LSU_STORE_MERGE: begin
          mem_wen   = 1'b1;
          mem_wdata = store_word;
          state_d   = LSU_IDLE;
        end
        default: begin
          state_d = LSU_IDLE;
        end
      endcase
    end
  end

  // State and latched request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory with registered read plus a byte-level reference model.
// Latency: checks the accept cycle and the completion cycle of every access.
// Backpressure: verifies stall is raised only in the accept cycle of 2-cycle accesses.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic        req_ren;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Memory seen by the DUT and the byte-addressed reference copy
  logic [31:0] tb_mem [0:DEPTH-1];
  logic [7:0]  ref_b  [0:4*DEPTH-1];

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_ren     (req_ren),
    .req_wen     (req_wen),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .mem_addr    (mem_addr),
    .mem_wen     (mem_wen),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port word memory: registered read, read-during-write returns old data
  always @(posedge clk) begin
    if (mem_wen && mem_addr[31:14] == 18'h0) tb_mem[mem_addr[13:2]] <= mem_wdata;
    mem_rdata <= (mem_addr[31:14] == 18'h0) ? tb_mem[mem_addr[13:2]] : 32'h0;
  end

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'h3;
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int sz, input bit uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[a + 32'(i)]) << (8 * i));
    if (!uns && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int sz, input logic [31:0] wd);
    for (int i = 0; i < sz; i++) ref_b[a + 32'(i)] = wd[8*i +: 8];
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    req_wen = 1'b0;
    req_ren = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Issue one access and check both its accept and completion cycles
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] obs);
    int          sz;
    bit          flt;
    logic [31:0] exp_v;
    logic [31:0] aligned;
    logic [3:0]  flags;
    sz      = acc_size(f3);
    flt     = ((a % 32'(sz)) != 0) || ((a >> 2) >= 32'(DEPTH));
    aligned = a & ~32'h3;
    obs     = 32'h0;
    @(posedge clk); #1;
    req_wen = st; req_ren = !st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    flags = {stall, fault, mem_wen, rdata_valid};
    if (flt) begin
      n_checks++;
      if (flags !== 4'b0100 || rdata !== 32'h0 || mem_wdata !== 32'h0) begin
        n_errors++;
        $display("FAIL fault_cycle a=%h f3=%b: got flags=%b rdata=%h wdata=%h, required flags=0100 rdata=0 wdata=0",
                 a, f3, flags, rdata, mem_wdata);
      end
    end else if (st && sz == 4) begin
      n_checks++;
      if (flags !== 4'b0010 || mem_wdata !== wd || mem_addr !== aligned) begin
        n_errors++;
        $display("FAIL sw_cycle a=%h: got flags=%b wdata=%h addr=%h, required flags=0010 wdata=%h addr=%h",
                 a, flags, mem_wdata, mem_addr, wd, aligned);
      end
      ref_store(a, 4, wd);
      obs = mem_wdata;
    end else begin
      n_checks++;
      if (flags !== 4'b1000 || mem_addr !== aligned || rdata !== 32'h0) begin
        n_errors++;
        $display("FAIL accept_cycle a=%h f3=%b st=%0d: got flags=%b addr=%h rdata=%h, required flags=1000 addr=%h rdata=0",
                 a, f3, st, flags, mem_addr, rdata, aligned);
      end
      @(negedge clk);
      flags = {stall, fault, mem_wen, rdata_valid};
      if (st) begin
        ref_store(a, sz, wd);
        exp_v = ref_word(a);
        n_checks++;
        if (flags !== 4'b0010 || mem_wdata !== exp_v || mem_addr !== aligned) begin
          n_errors++;
          $display("FAIL merge_cycle a=%h f3=%b: got flags=%b wdata=%h, required flags=0010 wdata=%h",
                   a, f3, flags, mem_wdata, exp_v);
        end
        obs = mem_wdata;
      end else begin
        exp_v = ref_load(a, sz, (f3[2] == 1'b1));
        n_checks++;
        if (flags !== 4'b0001 || rdata !== exp_v || mem_wdata !== 32'h0) begin
          n_errors++;
          $display("FAIL load_done a=%h f3=%b: got flags=%b rdata=%h, required flags=0001 rdata=%h",
                   a, f3, flags, rdata, exp_v);
        end
        obs = rdata;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_ren = 1'b1; req_wen = 1'b0; req_funct3 = LSU_LB;
    req_addr = 32'h101; req_wdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({stall, fault, mem_wen, rdata_valid} !== 4'b0000 || rdata !== 32'h0 || mem_wdata !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_outputs: got flags=%b rdata=%h wdata=%h, required all zero",
                 {stall, fault, mem_wen, rdata_valid}, rdata, mem_wdata);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; req_ren = 1'b0;
  endtask

  task automatic test_load_lanes();
    logic [2:0]  f3s  [5] = '{LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW};
    logic [31:0] adrs [5] = '{32'h101, 32'h103, 32'h100, 32'h102, 32'h100};
    logic [31:0] exps [5] = '{32'hFFFF_FF82, 32'h0000_0080, 32'hFFFF_82F3, 32'h0000_8081, 32'h8081_82F3};
    logic [31:0] obs;
    run_access(1'b1, LSU_SW, 32'h100, 32'h8081_82F3, obs);
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, f3s[i], adrs[i], 32'h0, obs);
      n_checks++;
      if (obs !== exps[i]) begin
        n_errors++;
        $display("FAIL load_lane_%0d: got %h, required %h", i, obs, exps[i]);
      end
    end
    // Unused load funct3 behaves as LW
    run_access(1'b0, 3'b110, 32'h100, 32'h0, obs);
    n_checks++;
    if (obs !== 32'h8081_82F3) begin
      n_errors++;
      $display("FAIL load_f3_110: got %h, required 808182f3", obs);
    end
    idle_cycles(2);
  endtask

  task automatic test_sw();
    logic [31:0] obs;
    run_access(1'b1, LSU_SW, 32'h100, 32'h1234_5678, obs);
    run_access(1'b0, LSU_LW, 32'h100, 32'h0, obs);
    n_checks++;
    if (obs !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL sw_readback: got %h, required 12345678", obs);
    end
    // Store funct3 011 behaves as SW
    run_access(1'b1, 3'b011, 32'h104, 32'hCAFE_F00D, obs);
    run_access(1'b0, LSU_LW, 32'h104, 32'h0, obs);
    n_checks++;
    if (obs !== 32'hCAFE_F00D) begin
      n_errors++;
      $display("FAIL store_f3_011: got %h, required cafef00d", obs);
    end
    idle_cycles(2);
  endtask

  task automatic test_rmw();
    logic [31:0] obs;
    run_access(1'b1, LSU_SW, 32'h100, 32'h8081_82F3, obs);
    run_access(1'b1, LSU_SB, 32'h102, 32'h0000_00AB, obs);
    n_checks++;
    if (obs !== 32'h80AB_82F3) begin
      n_errors++;
      $display("FAIL rmw_sb: got %h, required 80ab82f3", obs);
    end
    run_access(1'b1, LSU_SW, 32'h100, 32'h8081_82F3, obs);
    run_access(1'b1, LSU_SH, 32'h100, 32'h0000_BEEF, obs);
    n_checks++;
    if (obs !== 32'h8081_BEEF) begin
      n_errors++;
      $display("FAIL rmw_sh: got %h, required 8081beef", obs);
    end
    idle_cycles(2);
  endtask

  task automatic test_faults();
    logic [31:0] obs;
    run_access(1'b1, LSU_SW, 32'h100, 32'h8081_82F3, obs);
    run_access(1'b1, LSU_SH, 32'h101, 32'h0000_1111, obs);
    run_access(1'b0, LSU_LW, 32'h102, 32'h0, obs);
    run_access(1'b0, LSU_LW, 32'h0000_4000, 32'h0, obs);
    run_access(1'b1, LSU_SB, 32'hFFFF_FFFF, 32'h0, obs);
    run_access(1'b0, LSU_LW, 32'h100, 32'h0, obs);
    n_checks++;
    if (obs !== 32'h8081_82F3) begin
      n_errors++;
      $display("FAIL fault_no_write: got %h, required 808182f3", obs);
    end
    // Last in-range word
    run_access(1'b1, LSU_SW, 32'h0000_3FFC, 32'hA5A5_0F0F, obs);
    run_access(1'b0, LSU_LHU, 32'h0000_3FFE, 32'h0, obs);
    n_checks++;
    if (obs !== 32'h0000_A5A5) begin
      n_errors++;
      $display("FAIL last_word: got %h, required 0000a5a5", obs);
    end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs;
    run_access(1'b1, LSU_SW, 32'h100, 32'h8081_82F3, obs);
    run_access(1'b1, LSU_SB, 32'h100, 32'h0000_005A, obs);
    run_access(1'b0, LSU_LBU, 32'h100, 32'h0, obs);
    n_checks++;
    if (obs !== 32'h0000_005A) begin
      n_errors++;
      $display("FAIL back_to_back: got %h, required 0000005a", obs);
    end
    idle_cycles(2);
  endtask

  // Reset lands on the completion cycle of a multi-cycle access
  task automatic reset_mid_access(input bit st, input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    req_wen = st; req_ren = !st; req_funct3 = f3; req_addr = a; req_wdata = 32'h0000_00EE;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_accept: got stall=%b, required 1", stall);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({stall, fault, mem_wen, rdata_valid} !== 4'b0000 || rdata !== 32'h0 || mem_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_mid_complete st=%0d: got flags=%b rdata=%h wdata=%h, required all zero",
               st, {stall, fault, mem_wen, rdata_valid}, rdata, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_wen = 1'b0; req_ren = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs;
    run_access(1'b1, LSU_SW, 32'h100, 32'h8081_82F3, obs);
    idle_cycles(1);
    reset_mid_access(1'b1, LSU_SB, 32'h103);
    run_access(1'b0, LSU_LW, 32'h100, 32'h0, obs);
    n_checks++;
    if (obs !== 32'h8081_82F3) begin
      n_errors++;
      $display("FAIL rst_merge_abandon: got %h, required 808182f3", obs);
    end
    idle_cycles(1);
    reset_mid_access(1'b0, LSU_LB, 32'h101);
    run_access(1'b0, LSU_LB, 32'h101, 32'h0, obs);
    n_checks++;
    if (obs !== 32'hFFFF_FF82) begin
      n_errors++;
      $display("FAIL rst_load_recover: got %h, required ffffff82", obs);
    end
    idle_cycles(2);
  endtask

  task automatic test_random();
    logic [31:0] obs;
    logic [31:0] a;
    logic [2:0]  f3;
    bit          st;
    for (int w = 0; w < 8; w++) run_access(1'b1, LSU_SW, 32'h100 + 32'(4 * w), $urandom, obs);
    for (int n = 0; n < 200; n++) begin
      st = ($urandom_range(0, 1) == 1);
      f3 = st ? {1'b0, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = 32'h0000_4000 + 32'($urandom_range(0, 4095));
      run_access(st, f3, a, $urandom, obs);
    end
    idle_cycles(2);
  endtask

  initial begin
    rst = 1'b1; req_ren = 1'b0; req_wen = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_load_lanes();
    test_sw();
    test_rmw();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
